// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared across the calculator blocks.
//   state_e      - operand entry FSM states (ENTRY, FULL)
//   DEF_WIDTH    - default operand / switch bus width
//   DEF_NUM_OPS  - default number of operand slots per sequence
package calc_pkg;

  localparam int DEF_WIDTH   = 7;
  localparam int DEF_NUM_OPS = 2;

  typedef enum logic {
    ENTRY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector for the load button.
// Only compiled when LOAD_EDGE_DETECT_EN is defined; otherwise this file is empty.
//   clk    in  system clock
//   reset  in  synchronous active-high reset (clears history)
//   sig    in  level input
//   rise   out high for the cycle where sig is high and was low last cycle
`ifdef LOAD_EDGE_DETECT_EN
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  always_comb begin
    prev_d = sig;
  end

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign rise = sig & ~prev_q;

endmodule
`endif

// File: rtl/operand_capture.sv
// operand_capture: collects NUM_OPS operands of WIDTH bits from the switches.
// Build option: LOAD_EDGE_DETECT_EN - accept a load only on the rising edge of num.
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   sw         in   operand value
//   num        in   load strobe
//   en_in      in   load qualifier
//   clr        in   synchronous flush of the entry sequence
//   ack        in   consumer acknowledge of a full set
//   ops        out  captured operands, slot i at [i*WIDTH +: WIDTH]
//   op_idx     out  next slot to be written (NUM_OPS when full)
//   ops_valid  out  full operand set held
//
// state | meaning
// ENTRY | accepting loads into slot op_idx
// FULL  | all slots written, loads ignored until ack or clr
module operand_capture
  import calc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             sw,
  input  logic                         num,
  input  logic                         en_in,
  input  logic                         clr,
  input  logic                         ack,
  output logic [NUM_OPS*WIDTH-1:0]     ops,
  output logic [$clog2(NUM_OPS):0]     op_idx,
  output logic                         ops_valid
);

  localparam int IDX_W = $clog2(NUM_OPS) + 1;

  state_e                      state_d, state_q;
  logic [NUM_OPS*WIDTH-1:0]    ops_d, ops_q;
  logic [IDX_W-1:0]            idx_d, idx_q;
  logic                        load;

`ifdef LOAD_EDGE_DETECT_EN
  logic num_rise;

  edge_detect u_edge_detect (
    .clk   (clk),
    .reset (reset),
    .sig   (num),
    .rise  (num_rise)
  );

  assign load = num_rise & en_in;
`else
  assign load = num & en_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      ops_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = ENTRY;
      ops_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (load) begin
            for (int i = 0; i < NUM_OPS; i++) begin
              if (idx_q == IDX_W'(i)) ops_d[i*WIDTH +: WIDTH] = sw;
            end
            if (idx_q == IDX_W'(NUM_OPS - 1)) begin
              idx_d   = IDX_W'(NUM_OPS);
              state_d = FULL;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        FULL: begin
          // Slots keep their contents after ack so a display can still show them.
          if (ack) begin
            idx_d   = '0;
            state_d = ENTRY;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

  always_comb begin
    ops       = ops_q;
    op_idx    = idx_q;
    ops_valid = (state_q == FULL);
  end

endmodule

// File: tb/tb_operand_capture.sv
module tb_operand_capture;
  import calc_pkg::*;

  localparam int WIDTH   = DEF_WIDTH;
  localparam int NUM_OPS = DEF_NUM_OPS;
  localparam int IDX_W   = $clog2(NUM_OPS) + 1;

  logic                     clk = 1'b0;
  logic                     reset, num, en_in, clr, ack;
  logic [WIDTH-1:0]         sw;
  logic [NUM_OPS*WIDTH-1:0] ops;
  logic [IDX_W-1:0]         op_idx;
  logic                     ops_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_capture #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .num       (num),
    .en_in     (en_in),
    .clr       (clr),
    .ack       (ack),
    .ops       (ops),
    .op_idx    (op_idx),
    .ops_valid (ops_valid)
  );

  // Reference model: a list of entered operands plus a "set complete" flag.
  logic [WIDTH-1:0] m_slot [NUM_OPS];
  int               m_cnt;
  bit               m_full;
  bit               m_prev;

  task automatic model_edge();
    bit take;
    take = num && en_in;
`ifdef LOAD_EDGE_DETECT_EN
    take = take && !m_prev;
`endif
    if (reset) begin
      foreach (m_slot[i]) m_slot[i] = '0;
      m_cnt = 0; m_full = 0; m_prev = 0;
    end else begin
      if (clr) begin
        foreach (m_slot[i]) m_slot[i] = '0;
        m_cnt = 0; m_full = 0;
      end else if (m_full) begin
        if (ack) begin m_cnt = 0; m_full = 0; end
      end else if (take) begin
        m_slot[m_cnt] = sw;
        m_cnt++;
        if (m_cnt == NUM_OPS) m_full = 1;
      end
      m_prev = num;
    end
  endtask

  function automatic logic [63:0] m_ops();
    logic [63:0] r = '0;
    for (int i = 0; i < NUM_OPS; i++) r[i*WIDTH +: WIDTH] = m_slot[i];
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, "/ops"},   64'(ops),       m_ops());
    chk({tag, "/idx"},   64'(op_idx),    64'(m_cnt));
    chk({tag, "/valid"}, 64'(ops_valid), 64'(m_full));
  endtask

  task automatic drive(bit r, bit n, bit e, bit c, bit a, logic [WIDTH-1:0] s);
    reset = r; num = n; en_in = e; clr = c; ack = a; sw = s;
  endtask

  // Advance one clock edge, then compare against the model 1 time unit later.
  task automatic tick(string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    foreach (m_slot[i]) m_slot[i] = 'x;
    m_cnt = 0; m_full = 0; m_prev = 0;
    drive(1, 0, 0, 0, 0, '0);
    tick("rst0");
    tick("rst1");
    chk("reset_ops",   64'(ops),       64'h0);
    chk("reset_idx",   64'(op_idx),    64'd0);
    chk("reset_valid", 64'(ops_valid), 64'd0);

    // Two loads fill the set.
    drive(0, 1, 1, 0, 0, 7'h05); tick("load0");
    chk("idx_after_load0", 64'(op_idx), 64'd1);
    drive(0, 0, 1, 0, 0, 7'h00); tick("gap0");
    drive(0, 1, 1, 0, 0, 7'h0A); tick("load1");
    chk("full_ops",   64'(ops),       64'h0505);
    chk("full_idx",   64'(op_idx),    64'd2);
    chk("full_valid", 64'(ops_valid), 64'd1);
    drive(0, 0, 1, 0, 0, 7'h00); tick("gap1");

    // Loads ignored while full; ack empties the index but keeps slot contents.
    drive(0, 1, 1, 0, 0, 7'h7F); tick("full_load");
    drive(0, 0, 1, 0, 0, 7'h7F); tick("full_gap");
    chk("full_hold_ops", 64'(ops), 64'h0505);
    drive(0, 0, 0, 0, 1, 7'h00); tick("ack");
    chk("ack_valid", 64'(ops_valid), 64'd0);
    chk("ack_idx",   64'(op_idx),    64'd0);
    chk("ack_ops",   64'(ops),       64'h0505);
    drive(0, 0, 0, 0, 1, 7'h00); tick("ack_in_entry");

    // Refill, then ack and load on the same edge: load discarded.
    drive(0, 1, 1, 0, 0, 7'h01); tick("refill0");
    drive(0, 0, 1, 0, 0, 7'h00); tick("refill_gap");
    drive(0, 1, 1, 0, 0, 7'h02); tick("refill1");
    drive(0, 0, 1, 0, 0, 7'h00); tick("refill_gap2");
    drive(0, 1, 1, 0, 1, 7'h33); tick("ack_and_load");
    chk("ackload_idx", 64'(op_idx), 64'd0);
    chk("ackload_ops", 64'(ops),    64'h0101);
    drive(0, 0, 1, 0, 0, 7'h00); tick("ackload_gap");

    // clr mid-sequence, then next load lands in slot 0.
    drive(0, 1, 1, 0, 0, 7'h11); tick("pre_clr_load");
    drive(0, 0, 1, 1, 0, 7'h00); tick("clr");
    chk("clr_ops", 64'(ops),    64'h0);
    chk("clr_idx", 64'(op_idx), 64'd0);
    drive(0, 1, 1, 0, 0, 7'h22); tick("post_clr_load");
    chk("post_clr_ops", 64'(ops), 64'h22);

    // Qualifier low: nothing captured.
    drive(0, 0, 1, 1, 0, 7'h00); tick("clr2");
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 7'h5A); tick("no_en");
    end
    chk("no_en_idx", 64'(op_idx), 64'd0);

    // Reset mid-sequence.
    drive(0, 0, 1, 0, 0, 7'h00); tick("pre_rst_gap");
    drive(0, 1, 1, 0, 0, 7'h2B); tick("pre_rst_load");
    drive(1, 0, 0, 0, 0, 7'h00); tick("mid_rst");
    chk("mid_rst_ops", 64'(ops), 64'h0);
    drive(0, 1, 1, 0, 0, 7'h44); tick("post_rst_load");
    chk("post_rst_ops", 64'(ops),    64'h44);
    chk("post_rst_idx", 64'(op_idx), 64'd1);

    // Held button for three cycles.
    drive(0, 0, 1, 1, 0, 7'h00); tick("clr3");
    drive(0, 0, 1, 0, 0, 7'h00); tick("hold_pre");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 7'h15); tick("hold");
    end
`ifdef LOAD_EDGE_DETECT_EN
    chk("hold_idx", 64'(op_idx), 64'd1);
`else
    chk("hold_idx",   64'(op_idx),    64'd2);
    chk("hold_valid", 64'(ops_valid), 64'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) == 0), WIDTH'($urandom));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_capture.md
OPERAND_CAPTURE -- requirements
Module: operand_capture

Interface
REQ-001 Parameter WIDTH, default 7, bit width of one operand and of the switch bus.
REQ-002 Parameter NUM_OPS, default 2, number of operand slots captured per sequence (legal range 1..8).
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port sw  input  WIDTH  operand value from switches.
REQ-006 Port num  input  1  load strobe (user button).
REQ-007 Port en_in  input  1  load qualifier; a load needs num and en_in both high.
REQ-008 Port clr  input  1  synchronous flush of the entry sequence.
REQ-009 Port ack  input  1  consumer acknowledge of a complete operand set.
REQ-010 Port ops  output  NUM_OPS*WIDTH  captured operands; slot i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Port op_idx  output  clog2(NUM_OPS)+1  index of the next slot to be written.
REQ-012 Port ops_valid  output  1  high while a full operand set is held.

Function
REQ-013 The FSM SHALL have two states, ENTRY and FULL.
REQ-014 Load accepted = num & en_in (qualified per REQ-026/027), in ENTRY only.
REQ-015 In ENTRY, an accepted load SHALL write sw into slot op_idx and increment op_idx; the new value SHALL be visible on ops one cycle after the sampling edge.
REQ-016 A load into slot NUM_OPS-1 SHALL set op_idx to NUM_OPS, move to FULL, and assert ops_valid in the same cycle that the last slot becomes visible.
REQ-017 In FULL, loads SHALL be ignored; ops and op_idx SHALL hold.
REQ-018 In FULL, ack high SHALL clear op_idx to 0, deassert ops_valid next cycle, and return to ENTRY.
REQ-019 Ack in ENTRY SHALL be ignored.
REQ-020 Operand slots SHALL retain old contents after ack until overwritten (display use).
REQ-021 clr high SHALL zero all slots, set op_idx to 0, deassert ops_valid, and enter ENTRY, regardless of state.
REQ-022 Priority on a single edge: reset > clr > ack > load; a load coinciding with ack in FULL SHALL be discarded.
REQ-023 NUM_OPS=1: every accepted load SHALL go directly to FULL.

Reset
REQ-024 Reset SHALL set all ops to 0, op_idx to 0, ops_valid to 0, the state to ENTRY, and the edge-detect history to 0.
REQ-025 Reset asserted mid-sequence SHALL discard partially entered operands; the first load after reset SHALL write slot 0.

Configuration
REQ-026 With LOAD_EDGE_DETECT_EN defined, a load SHALL be accepted only on a cycle where num is high and was low the previous cycle (and en_in is high); holding num SHALL capture exactly once.
REQ-027 Without LOAD_EDGE_DETECT_EN, a load SHALL be accepted on every cycle that num & en_in is high; holding num for k cycles SHALL fill up to k slots.

Structure
REQ-028 Shared package calc_pkg SHALL hold the state enum (ENTRY, FULL) and the default WIDTH/NUM_OPS constants used across the calculator.
REQ-029 Edge detection SHALL be a sub-module named edge_detect (one register plus rising-edge output), instantiated only under LOAD_EDGE_DETECT_EN.

Verification
REQ-030 Reset, then loads sw=7'h05 and sw=7'h0A (NUM_OPS=2) -> ops=14'h0505 (slot0=05, slot1=0A), ops_valid=1 one cycle after the 2nd load, op_idx=2.
REQ-031 In FULL, pulse num with sw=7'h7F -> ops unchanged; then ack -> ops_valid=0, op_idx=0, and slot contents still 05/0A.
REQ-032 ack and a load on the same edge in FULL -> state ENTRY, op_idx=0, and no slot written.
REQ-033 After one load (op_idx=1), assert clr, or separately reset -> ops=0, op_idx=0, ops_valid=0; the next load writes slot 0.
REQ-034 Hold num high for 3 cycles with en_in=1 -> with LOAD_EDGE_DETECT_EN, op_idx=1; without it, FULL reached after 2 cycles.
REQ-035 num high with en_in=0 for 5 cycles -> no slot written, op_idx=0.
